// File: rtl/hamming_pkg.sv
// Shared types and helpers for the byte-serial SECDED decoder.
// Holds the FSM encoding, status codes and the codeword data map.
package hamming_pkg;

  typedef enum logic [1:0] {
    S_LSW,
    S_MSW,
    S_DEC,
    S_OUT
  } state_t;

  localparam logic [1:0] ST_CLEAN  = 2'b00;
  localparam logic [1:0] ST_SINGLE = 2'b01;
  localparam logic [1:0] ST_DOUBLE = 2'b10;

  localparam int DATA_BITS = 11;
  localparam int CW_BITS   = 16;

  // Codeword position of data bit i; parity bits sit at 0,1,2,4,8.
  function automatic logic [3:0] data_pos(
    input int i
  );
    logic [3:0] p;
    p = 4'd0;
    unique case (i)
      0:  p = 4'd3;
      1:  p = 4'd5;
      2:  p = 4'd6;
      3:  p = 4'd7;
      4:  p = 4'd9;
      5:  p = 4'd10;
      6:  p = 4'd11;
      7:  p = 4'd12;
      8:  p = 4'd13;
      9:  p = 4'd14;
      10: p = 4'd15;
      default: p = 4'd0;
    endcase
    return p;
  endfunction

  function automatic logic [DATA_BITS-1:0] extract_data(
    input logic [CW_BITS-1:0] cw
  );
    logic [DATA_BITS-1:0] d;
    d = '0;
    for (int i = 0; i < DATA_BITS; i++) begin
      d[i] = cw[data_pos(i)];
    end
    return d;
  endfunction

  function automatic logic [7:0] sat_inc(
    input logic [7:0] v
  );
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/hamming_syndrome.sv
// Combinational syndrome and overall-parity generator for a 16-bit
// Hamming codeword; bit 0 only contributes to the parity.
module hamming_syndrome
  import hamming_pkg::*;
(
  input  logic [CW_BITS-1:0] word,
  output logic [3:0]         syndrome,
  output logic               parity
);

  always_comb begin
    syndrome = 4'd0;
    for (int i = 1; i < CW_BITS; i++) begin
      if (word[i]) begin
        syndrome = syndrome ^ 4'(i);
      end
    end
  end

  assign parity = ^word;

endmodule

// File: rtl/hamming_decoder.sv
// Byte-serial SECDED decoder: collects LSW/MSW, corrects single errors,
// flags doubles and keeps saturating error counters.
module hamming_decoder
  import hamming_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [7:0] in_byte,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [7:0] out_lsw,
  output logic [7:0] out_msw,
  output logic [1:0] out_status,
  output logic [3:0] out_syndrome,
  output logic [7:0] cnt_single,
  output logic [7:0] cnt_double
);

  state_t state;
  state_t state_nxt;

  logic [CW_BITS-1:0]   cw;
  logic [CW_BITS-1:0]   fixed;
  logic [DATA_BITS-1:0] data;
  logic [3:0]           syn;
  logic                 par;
  logic [1:0]           status;

  hamming_syndrome u_syn (
    .word     (cw),
    .syndrome (syn),
    .parity   (par)
  );

  // Odd parity means one flip; syndrome 0 then points at p0.
  always_comb begin
    fixed  = cw;
    status = ST_CLEAN;
    if (par) begin
      fixed  = cw ^ (16'd1 << syn);
      status = ST_SINGLE;
    end else if (syn != 4'd0) begin
      status = ST_DOUBLE;
    end
    data = extract_data(fixed);
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      S_LSW: if (in_valid) state_nxt = S_MSW;
      S_MSW: if (in_valid) state_nxt = S_DEC;
      S_DEC: state_nxt = S_OUT;
      S_OUT: if (out_ready) state_nxt = S_LSW;
      default: state_nxt = S_LSW;
    endcase
  end

  assign in_ready  = (state == S_LSW) ||
                     (state == S_MSW);
  assign out_valid = (state == S_OUT);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= S_LSW;
    end else begin
      state <= state_nxt;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cw           <= '0;
      out_lsw      <= '0;
      out_msw      <= '0;
      out_status   <= ST_CLEAN;
      out_syndrome <= '0;
      cnt_single   <= '0;
      cnt_double   <= '0;
    end else begin
      unique case (state)
        S_LSW: if (in_valid) cw[7:0]  <= in_byte;
        S_MSW: if (in_valid) cw[15:8] <= in_byte;
        S_DEC: begin
          out_lsw      <= data[7:0];
          out_msw      <= {status, 3'b000, data[10:8]};
          out_status   <= status;
          out_syndrome <= syn;
          if (status == ST_SINGLE) begin
            cnt_single <= sat_inc(cnt_single);
          end
          if (status == ST_DOUBLE) begin
            cnt_double <= sat_inc(cnt_double);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_hamming_decoder.sv
// Self-checking bench for hamming_decoder: directed vectors plus random
// words with 0/1/2 injected errors against an error-count based model.
module tb_hamming_decoder;

  logic       clk = 1'b0;
  logic       reset;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_byte;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_lsw;
  logic [7:0] out_msw;
  logic [1:0] out_status;
  logic [3:0] out_syndrome;
  logic [7:0] cnt_single;
  logic [7:0] cnt_double;

  int checks = 0;
  int errors = 0;
  int m_single = 0;
  int m_double = 0;
  int dp[11] = '{3, 5, 6, 7, 9, 10, 11, 12, 13, 14, 15};

  always #5 clk = ~clk;

  hamming_decoder dut (
    .clk          (clk),
    .reset        (reset),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_byte      (in_byte),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_lsw      (out_lsw),
    .out_msw      (out_msw),
    .out_status   (out_status),
    .out_syndrome (out_syndrome),
    .cnt_single   (cnt_single),
    .cnt_double   (cnt_double)
  );

  task automatic check(
    input string       tag,
    input logic [31:0] got,
    input logic [31:0] exp
  );
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] encode(input logic [10:0] d);
    logic [15:0] w;
    int s;
    w = '0;
    s = 0;
    for (int i = 0; i < 11; i++) begin
      w[dp[i]] = d[i];
      if (d[i]) s = s ^ dp[i];
    end
    w[1] = s[0];
    w[2] = s[1];
    w[4] = s[2];
    w[8] = s[3];
    w[0] = ^w[15:1];
    return w;
  endfunction

  function automatic logic [10:0] pick_data(input logic [15:0] w);
    logic [10:0] d;
    for (int i = 0; i < 11; i++) d[i] = w[dp[i]];
    return d;
  endfunction

  task automatic send_byte(input logic [7:0] b);
    int n;
    n = 0;
    in_valid = 1'b1;
    in_byte  = b;
    while (!in_ready && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    check("in_ready", 32'(in_ready), 32'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic run_word(
    input logic [15:0] w,
    input logic [7:0]  e_lsw,
    input logic [7:0]  e_msw,
    input logic [1:0]  e_st,
    input logic [3:0]  e_syn,
    input int          hold
  );
    send_byte(w[7:0]);
    send_byte(w[15:8]);
    check("lat_dec", 32'(out_valid), 32'd0);
    if (e_st == 2'b01 && m_single < 255) m_single++;
    if (e_st == 2'b10 && m_double < 255) m_double++;
    @(posedge clk); #1;
    check("lat_out", 32'(out_valid), 32'd1);
    for (int c = 0; c <= hold; c++) begin
      check("valid_hold", 32'(out_valid), 32'd1);
      check("rdy_hold", 32'(in_ready), 32'd0);
      check("lsw", 32'(out_lsw), 32'(e_lsw));
      check("msw", 32'(out_msw), 32'(e_msw));
      check("status", 32'(out_status), 32'(e_st));
      check("syndrome", 32'(out_syndrome), 32'(e_syn));
      check("cnt_single", 32'(cnt_single), 32'(m_single));
      check("cnt_double", 32'(cnt_double), 32'(m_double));
      if (c < hold) begin
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
      end
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check("post_rdy", 32'(in_ready), 32'd1);
    check("post_val", 32'(out_valid), 32'd0);
  endtask

  task automatic run_random(input int nerr, input int hold);
    logic [10:0] d;
    logic [10:0] ed;
    logic [15:0] w;
    logic [1:0]  st;
    int          a;
    int          b;
    int          syn;
    d = 11'($urandom);
    w = encode(d);
    a = $urandom_range(0, 15);
    b = (a + $urandom_range(1, 15)) % 16;
    ed = d;
    syn = 0;
    st = 2'b00;
    if (nerr == 1) begin
      w[a] = ~w[a];
      syn = a;
      st = 2'b01;
    end else if (nerr == 2) begin
      w[a] = ~w[a];
      w[b] = ~w[b];
      syn = a ^ b;
      st = 2'b10;
      ed = pick_data(w);
    end
    run_word(w, ed[7:0], {st, 3'b000, ed[10:8]}, st, 4'(syn), hold);
  endtask

  initial begin
    reset     = 1'b1;
    in_valid  = 1'b0;
    in_byte   = 8'h00;
    out_ready = 1'b0;
    #12;
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_lsw", 32'(out_lsw), 32'd0);
    check("rst_msw", 32'(out_msw), 32'd0);
    check("rst_status", 32'(out_status), 32'd0);
    check("rst_syn", 32'(out_syndrome), 32'd0);
    check("rst_cnt_s", 32'(cnt_single), 32'd0);
    check("rst_cnt_d", 32'(cnt_double), 32'd0);
    @(posedge clk); #1;
    reset = 1'b0;

    run_word(16'hFFFF, 8'hFF, 8'h07, 2'b00, 4'h0, 0);
    run_word(16'hFFDF, 8'hFF, 8'h47, 2'b01, 4'h5, 0);
    run_word(16'hFFFE, 8'hFF, 8'h47, 2'b01, 4'h0, 0);
    run_word(16'hFDF7, 8'hEE, 8'h87, 2'b10, 4'hA, 10);

    for (int i = 0; i < 200; i++) begin
      run_random($urandom_range(0, 2), $urandom_range(0, 3));
    end
    for (int i = 0; i < 300; i++) begin
      run_random(1, 0);
    end
    check("sat_single", 32'(cnt_single), 32'hFF);

    send_byte(8'h12);
    #2 reset = 1'b1;
    #1;
    m_single = 0;
    m_double = 0;
    check("mid_rst_rdy", 32'(in_ready), 32'd1);
    check("mid_rst_val", 32'(out_valid), 32'd0);
    check("mid_rst_cnt_s", 32'(cnt_single), 32'd0);
    check("mid_rst_cnt_d", 32'(cnt_double), 32'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    run_word(16'h0000, 8'h00, 8'h00, 2'b00, 4'h0, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/hamming_decoder.md
# hamming_decoder

Byte-serial SECDED decoder for the 16-bit Hamming words produced by the ALU's parity and packaging ops. It takes the encoded LSW then MSW on an 8-bit valid/ready input and computes the syndrome and overall parity. It corrects any single-bit error, flags double errors, and returns the 11 data bits as two bytes in the memory result format. It sits beside the ALU on the 8-bit datapath as the hardware counterpart of the decode program, and also keeps saturating error statistics.

## Interface
- No parameters; all widths are fixed by the 16-bit codeword and 8-bit datapath.
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-high
- in_valid  in  1  in_byte holds a codeword byte
- in_ready  out  1  decoder accepts a byte this cycle
- in_byte  in  8  LSW (codeword bits 7:0) first, then MSW (bits 15:8)
- out_valid  out  1  result held stable until accepted
- out_ready  in  1  consumer accepts result
- out_lsw  out  8  decoded data d7..d0
- out_msw  out  8  {status[1:0], 3'b000, d10..d8}
- out_status  out  2  00 clean, 01 single corrected, 10 double detected
- out_syndrome  out  4  raw syndrome, for debug
- cnt_single  out  8  saturating count of corrected words
- cnt_double  out  8  saturating count of double-error words

## Operation
- Codeword map, by bit position:
  - 0 = p0 (overall parity); 1, 2, 4, 8 = p1, p2, p4, p8.
  - 3 = d0; 5..7 = d1..d3; 9..15 = d4..d10.
- Syndrome s[3:0] = XOR of the indices i (1..15) whose bit is 1. P = XOR of all 16 bits.
- Decode rules:
  - s==0, P==0: status 00, no correction.
  - P==1: status 01; flip bit s. When s==0, the flipped bit is p0 and the data is unchanged.
  - s!=0, P==0: status 10; data is extracted uncorrected.
- FSM states: S_LSW → S_MSW → S_DEC → S_OUT → S_LSW.
  - S_LSW: in_ready=1. On in_valid, capture the LSW and go to S_MSW.
  - S_MSW: in_ready=1. On in_valid, capture the MSW and go to S_DEC.
  - S_DEC: in_ready=0. Register the decode results and counter updates, then go to S_OUT.
  - S_OUT: out_valid=1. On out_ready, go to S_LSW.
- Counters increment once per decoded word, in S_DEC, and saturate at 8'hFF. They clear only on reset.
- Outputs are registered. out_* is held stable throughout S_OUT.

## Timing
- Reset values:
  - State S_LSW, so in_ready=1.
  - out_valid=0.
  - out_lsw, out_msw, out_status, out_syndrome = 0.
  - Both counters = 0.
- Latency: the MSW handshake edge is at cycle k. out_valid rises at cycle k+2.
- After out_valid&&out_ready at cycle m, in_ready=1 at cycle m+1. There is no overlap between consecutive words.
- While out_ready is held low, out_valid stays high indefinitely and in_ready stays 0.
- A reset asserted mid-word, after the LSW and before the output handshake, discards the partial word. The block returns to reset values asynchronously.
- in_valid is ignored in S_DEC and S_OUT.

## Structure
- hamming_pkg holds:
  - the state enum;
  - status constants ST_CLEAN, ST_SINGLE, ST_DOUBLE;
  - functions extract_data(16b) → 11b and the position map.
- Sub-module hamming_syndrome: combinational, 16-bit word in; s[3:0] and P out. It is reusable by the verification model.
- Top: FSM, codeword register, correction mux, output registers, counters.

## Test plan
- Clean word: LSW 0xFF, MSW 0xFF → out_lsw 0xFF, out_msw 0x07, status 00, syndrome 0. out_valid is seen exactly 2 cycles after the MSW accept.
- Single data-bit error: LSW 0xDF, MSW 0xFF (bit 5 flipped) → syndrome 5, status 01, out_lsw 0xFF, out_msw 0x47, cnt_single 1.
- p0 error: LSW 0xFE, MSW 0xFF → syndrome 0, status 01, out_lsw 0xFF, out_msw 0x47.
- Double error: LSW 0xF7, MSW 0xFD (bits 3 and 9 flipped) → syndrome 0xA, status 10, out_lsw 0xEE, out_msw 0x87, cnt_double 1.
- Backpressure and saturation:
  - Hold out_ready=0 for 10 cycles: out_valid stays 1, outputs stable, in_ready 0.
  - Feed 300 single-error words: cnt_single stays at 0xFF.
- Reset mid-operation: accept LSW 0x12, then pulse reset → in_ready=1 and out_valid=0 immediately. A following LSW 0x00 / MSW 0x00 decodes to 0x00 / 0x00 with status 00.
